// File: rtl/dms_pfd.sv
// Clocked phase-frequency detector: synchronizes ref/fb clocks, measures the lead/lag
// in clk cycles, drives width-matched up/down pulses and reports phase error and lock.
module dms_pfd #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int MIN_PULSE   = 2,
  parameter int MAX_PULSE   = 64,
  parameter int TIMEOUT     = 200,
  parameter int LOCK_WIN    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic             up,
  output logic             down,
  output logic [CNT_W:0]   phase_err,
  output logic             err_valid,
  output logic             lock,
  output logic             overrun,
  output logic [1:0]       dbg_state
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WIN   = CNT_W'(LOCK_WIN);
  localparam logic [LW-1:0]    L_MAX = LW'(LOCK_CNT);
  localparam logic [LW-1:0]    L_ONE = LW'(1);
  localparam logic [CNT_W:0]   E_ONE = (CNT_W+1)'(1);

  typedef enum logic [1:0] {IDLE, LEAD, LAG, HOLD} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hold_cnt;
  logic [LW-1:0]          lock_cnt;
  logic                   in_win;
  logic [SYNC_STAGES-1:0] ref_sync;
  logic [SYNC_STAGES-1:0] fb_sync;
  logic                   ref_hist;
  logic                   fb_hist;
  logic                   ref_e;
  logic                   fb_e;

  assign ref_e     = ref_sync[SYNC_STAGES-1] & ~ref_hist;
  assign fb_e      = fb_sync[SYNC_STAGES-1] & ~fb_hist;
  assign dbg_state = state;

  // Synchronizers run regardless of en so edges are clean when the loop re-enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_hist <= 1'b0;
      fb_hist  <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
      fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
      ref_hist <= ref_sync[SYNC_STAGES-1];
      fb_hist  <= fb_sync[SYNC_STAGES-1];
    end
  end

  // err_valid is a one-cycle strobe with no back-pressure: phase_err is valid
  // exactly in the cycle err_valid is high and holds until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_cnt  <= '0;
      lock_cnt  <= '0;
      in_win    <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      lock      <= 1'b0;
      overrun   <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_cnt  <= '0;
      lock_cnt  <= '0;
      in_win    <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      lock      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      err_valid <= 1'b0;

      if (err_valid) begin
        if (in_win) begin
          if (lock_cnt != L_MAX) begin
            lock_cnt <= lock_cnt + L_ONE;
            lock     <= (lock_cnt == L_MAX - L_ONE);
          end
        end else begin
          lock_cnt <= '0;
          lock     <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (ref_e && fb_e) begin
            state     <= HOLD;
            hold_cnt  <= MIN_P - C_ONE;
            up        <= 1'b1;
            down      <= 1'b1;
            phase_err <= '0;
            err_valid <= 1'b1;
            in_win    <= 1'b1;
          end else if (ref_e) begin
            state <= LEAD;
            cnt   <= C_ONE;
            up    <= 1'b1;
          end else if (fb_e) begin
            state <= LAG;
            cnt   <= C_ONE;
            down  <= 1'b1;
          end
        end

        LEAD: begin
          if (fb_e) begin
            phase_err <= {1'b0, cnt};
            err_valid <= 1'b1;
            in_win    <= (cnt <= WIN);
            cnt       <= '0;
            if (cnt >= MIN_P) begin
              state <= IDLE;
              up    <= 1'b0;
            end else begin
              // Stretch the pulse so the charge pump always sees MIN_PULSE cycles.
              state    <= HOLD;
              hold_cnt <= MIN_P - C_ONE - cnt;
            end
          end else if (ref_e) begin
            cnt      <= C_ONE;
            up       <= 1'b1;
            lock_cnt <= '0;
            lock     <= 1'b0;
          end else if (cnt >= TMO) begin
            state     <= IDLE;
            cnt       <= '0;
            up        <= 1'b0;
            phase_err <= {1'b0, TMO};
            err_valid <= 1'b1;
            in_win    <= 1'b0;
            lock_cnt  <= '0;
            lock      <= 1'b0;
          end else begin
            cnt <= cnt + C_ONE;
            up  <= (cnt + C_ONE <= MAX_P);
          end
        end

        LAG: begin
          if (ref_e) begin
            phase_err <= ~{1'b0, cnt} + E_ONE;
            err_valid <= 1'b1;
            in_win    <= (cnt <= WIN);
            cnt       <= '0;
            if (cnt >= MIN_P) begin
              state <= IDLE;
              down  <= 1'b0;
            end else begin
              state    <= HOLD;
              hold_cnt <= MIN_P - C_ONE - cnt;
            end
          end else if (fb_e) begin
            cnt      <= C_ONE;
            down     <= 1'b1;
            lock_cnt <= '0;
            lock     <= 1'b0;
          end else if (cnt >= TMO) begin
            state     <= IDLE;
            cnt       <= '0;
            down      <= 1'b0;
            phase_err <= ~{1'b0, TMO} + E_ONE;
            err_valid <= 1'b1;
            in_win    <= 1'b0;
            lock_cnt  <= '0;
            lock      <= 1'b0;
          end else begin
            cnt  <= cnt + C_ONE;
            down <= (cnt + C_ONE <= MAX_P);
          end
        end

        HOLD: begin
          if (ref_e || fb_e) overrun <= 1'b1;
          if (hold_cnt == '0) begin
            state <= IDLE;
            up    <= 1'b0;
            down  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - C_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dms_pfd.sv
// Directed bench for dms_pfd: stimulus pushes expected phase errors and pulse widths
// into queues; monitors pop and compare when the DUT strobes or ends a pulse.
module tb_dms_pfd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       ref_in = 1'b0;
  logic       fb_in = 1'b0;
  logic       up;
  logic       down;
  logic [8:0] phase_err;
  logic       err_valid;
  logic       lock;
  logic       overrun;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int lk = 0;

  logic [8:0] exp_q[$];
  logic [7:0] up_q[$];
  logic [7:0] dn_q[$];

  int   up_run = 0;
  int   dn_run = 0;
  logic prev_ev = 1'b0;

  dms_pfd dut (
    .clk(clk), .rst(rst), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .up(up), .down(down), .phase_err(phase_err), .err_valid(err_valid),
    .lock(lock), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // monitor: phase error strobes and pulse widths, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      up_run  = 0;
      dn_run  = 0;
      prev_ev = 1'b0;
    end else begin
      if (err_valid) begin
        chk("err_valid_one_cycle", {31'b0, prev_ev}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err_valid: got phase_err 0x%0h, none expected", phase_err);
        end else begin
          chk("phase_err", {23'b0, phase_err}, {23'b0, exp_q.pop_front()});
        end
      end
      prev_ev = err_valid;

      if (up) up_run++;
      else if (up_run > 0) begin
        if (up_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_up_pulse: got width %0d, none expected", up_run);
        end else chk("up_width", up_run, {24'b0, up_q.pop_front()});
        up_run = 0;
      end

      if (down) dn_run++;
      else if (dn_run > 0) begin
        if (dn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_down_pulse: got width %0d, none expected", dn_run);
        end else chk("down_width", dn_run, {24'b0, dn_q.pop_front()});
        dn_run = 0;
      end
    end
  end

  function automatic int pulse_w(input int ad);
    int w;
    w = (ad < 2) ? 2 : ad;
    if (w > 64) w = 64;
    return w;
  endfunction

  function automatic void lock_model(input int ad);
    if (ad <= 2) lk = (lk < 16) ? lk + 1 : 16;
    else lk = 0;
  endfunction

  // driver: d>0 ref leads fb by d cycles, d<0 fb leads, d==0 simultaneous
  task automatic run_cmp(input int d);
    int ad;
    logic [8:0] e;
    ad = (d < 0) ? -d : d;
    e  = d[8:0];
    exp_q.push_back(e);
    if (d >= 0) up_q.push_back(8'(pulse_w(ad)));
    if (d <= 0) dn_q.push_back(8'(pulse_w(ad)));
    @(negedge clk);
    if (d >= 0) ref_in = 1'b1;
    if (d <= 0) fb_in = 1'b1;
    repeat (ad) @(negedge clk);
    ref_in = 1'b1;
    fb_in  = 1'b1;
    repeat (4) @(negedge clk);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (20) @(negedge clk);
    lock_model(ad);
    chk("lock_track", {31'b0, lock}, (lk == 16) ? 32'd1 : 32'd0);
  endtask

  int lock_seq[16] = '{1, -1, 2, -2, 0, 1, 2, -2, -1, 0, 1, 1, -2, 2, 0, -1};

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_up", {31'b0, up}, 0);
    chk("rst_down", {31'b0, down}, 0);
    chk("rst_err_valid", {31'b0, err_valid}, 0);
    chk("rst_phase_err", {23'b0, phase_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_state", {30'b0, dbg_state}, 0);
    chk("idle_lock", {31'b0, lock}, 0);
    chk("idle_overrun", {31'b0, overrun}, 0);

    run_cmp(5);
    run_cmp(-1);
    run_cmp(0);
    run_cmp(70);

    // fb never arrives: comparison abandoned at TIMEOUT
    exp_q.push_back(9'd200);
    up_q.push_back(8'd64);
    @(negedge clk);
    ref_in = 1'b1;
    repeat (5) @(negedge clk);
    ref_in = 1'b0;
    repeat (215) @(negedge clk);
    lk = 0;
    chk("lock_after_timeout", {31'b0, lock}, 0);

    foreach (lock_seq[i]) run_cmp(lock_seq[i]);
    chk("lock_after_16", {31'b0, lock}, 1);
    run_cmp(3);
    chk("lock_dropped", {31'b0, lock}, 0);

    // second ref edge lands while HOLD is active
    exp_q.push_back(9'd0);
    up_q.push_back(8'd2);
    dn_q.push_back(8'd2);
    @(negedge clk);
    ref_in = 1'b1; fb_in = 1'b1;
    @(negedge clk);
    ref_in = 1'b0;
    @(negedge clk);
    ref_in = 1'b1;
    repeat (4) @(negedge clk);
    ref_in = 1'b0; fb_in = 1'b0;
    repeat (20) @(negedge clk);
    lock_model(0);
    chk("overrun_set", {31'b0, overrun}, 1);

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_overrun", {31'b0, overrun}, 0);
    chk("en_lock", {31'b0, lock}, 0);
    chk("en_phase_err", {23'b0, phase_err}, 0);
    chk("en_state", {30'b0, dbg_state}, 0);
    en = 1'b1;
    lk = 0;
    repeat (4) @(negedge clk);

    // async reset in the middle of an up pulse
    ref_in = 1'b1;
    repeat (12) @(negedge clk);
    chk("up_before_rst", {31'b0, up}, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_up", {31'b0, up}, 0);
    chk("async_rst_state", {30'b0, dbg_state}, 0);
    chk("async_rst_err_valid", {31'b0, err_valid}, 0);
    ref_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lk = 0;
    repeat (3) @(negedge clk);
    run_cmp(3);
    run_cmp(-4);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("up_q_drained", up_q.size(), 0);
    chk("dn_q_drained", dn_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
